// File: rtl/sonar_ranger_if.sv
// Sensor-side and result-side signals of the ultrasonic ranger, grouped so the
// ranger and its consumer agree on one bundle.
interface sonar_ranger_if #(
  parameter int DIST_W = 7
) ();
  logic              echo;
  logic              trig;
  logic [DIST_W-1:0] distance_cm;
  logic              dist_valid;
  logic              timeout;
  logic              saturated;
  logic              busy;

  modport master (
    input  echo,
    output trig, distance_cm, dist_valid, timeout, saturated, busy
  );

  modport slave (
    output echo,
    input  trig, distance_cm, dist_valid, timeout, saturated, busy
  );
endinterface

// File: rtl/sonar_ranger.sv
// Self-timed ultrasonic ranger: periodic trigger, synchronised echo-width
// measurement, prescaled conversion to whole centimetres with saturation.
module sonar_ranger #(
  parameter int PERIOD_CYCLES = 6750000,
  parameter int TRIG_CYCLES   = 270,
  parameter int CLKS_PER_CM   = 1566,
  parameter int RISE_TIMEOUT  = 27000,
  parameter int DIST_W        = 7,
  parameter int MAX_CM        = 127
) (
  input  logic           clk,
  input  logic           rst,
  sonar_ranger_if.master bus
);

  localparam int PER_W   = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TRIG_W  = (TRIG_CYCLES   > 1) ? $clog2(TRIG_CYCLES)   : 1;
  localparam int WAIT_W  = (RISE_TIMEOUT  > 1) ? $clog2(RISE_TIMEOUT)  : 1;
  localparam int PRESC_W = (CLKS_PER_CM   > 1) ? $clog2(CLKS_PER_CM)   : 1;

  localparam logic [PER_W-1:0]   PER_LAST   = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [TRIG_W-1:0]  TRIG_LAST  = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(RISE_TIMEOUT - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_CM - 1);
  localparam logic [DIST_W-1:0]  CM_MAX     = DIST_W'(MAX_CM);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [TRIG_W-1:0]   trig_cnt_q, trig_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [DIST_W-1:0]   cm_q, cm_d;
  logic                sat_q, sat_d;
  logic                echo_m_q, echo_m_d;
  logic                echo_s_q, echo_s_d;
  logic                echo_p_q, echo_p_d;
  logic [DIST_W-1:0]   distance_q, distance_d;
  logic                saturated_q, saturated_d;
  logic                timeout_q, timeout_d;

  logic tick;
  logic rise;
  logic fall;
  logic count_en;

  assign tick = (per_q == '0);
  assign rise = echo_s_q & ~echo_p_q;
  assign fall = ~echo_s_q & echo_p_q;

  always_comb begin
    state_d     = state_q;
    trig_cnt_d  = trig_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    presc_d     = presc_q;
    cm_d        = cm_q;
    sat_d       = sat_q;
    distance_d  = distance_q;
    saturated_d = saturated_q;
    timeout_d   = 1'b0;
    count_en    = 1'b0;
    echo_m_d    = bus.echo;
    echo_s_d    = echo_m_q;
    echo_p_d    = echo_s_q;
    per_d       = (per_q == PER_LAST) ? '0 : per_q + PER_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d    = ST_TRIG;
          trig_cnt_d = '0;
        end
      end
      ST_TRIG: begin
        presc_d = '0;
        cm_d    = '0;
        sat_d   = 1'b0;
        if (trig_cnt_q == TRIG_LAST) begin
          state_d    = ST_WAIT_RISE;
          wait_cnt_d = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + TRIG_W'(1);
        end
      end
      ST_WAIT_RISE: begin
        // The rise cycle itself is the first echo-high cycle of the measurement.
        if (rise) begin
          state_d  = ST_MEASURE;
          count_en = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_MEASURE: begin
        // Result is latched on the fall so it appears together with the DONE strobe.
        if (fall) begin
          state_d     = ST_DONE;
          distance_d  = cm_q;
          saturated_d = sat_q;
        end else begin
          count_en = echo_s_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (count_en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (cm_q == CM_MAX) begin
          sat_d = 1'b1;
        end else begin
          cm_d = cm_q + DIST_W'(1);
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      per_q       <= '0;
      trig_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      presc_q     <= '0;
      cm_q        <= '0;
      sat_q       <= 1'b0;
      echo_m_q    <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_p_q    <= 1'b0;
      distance_q  <= '0;
      saturated_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      trig_cnt_q  <= trig_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      presc_q     <= presc_d;
      cm_q        <= cm_d;
      sat_q       <= sat_d;
      echo_m_q    <= echo_m_d;
      echo_s_q    <= echo_s_d;
      echo_p_q    <= echo_p_d;
      distance_q  <= distance_d;
      saturated_q <= saturated_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.trig        = (state_q == ST_TRIG);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.dist_valid  = (state_q == ST_DONE);
  assign bus.timeout     = timeout_q;
  assign bus.distance_cm = distance_q;
  assign bus.saturated   = saturated_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed and randomised ranging sequences checked against an arithmetic model
// of trigger timing, echo-width conversion and strobe placement.
module tb_sonar_ranger;

  localparam int PERIOD = 200;
  localparam int TRIGC  = 4;
  localparam int CPC    = 3;
  localparam int RTO    = 50;
  localparam int MAXCM  = 20;
  localparam int DW     = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rel0;
  int   exp_trig;
  int   last_dist;
  int   last_sat;

  sonar_ranger_if #(.DIST_W(DW)) sif ();

  sonar_ranger #(
    .PERIOD_CYCLES(PERIOD),
    .TRIG_CYCLES  (TRIGC),
    .CLKS_PER_CM  (CPC),
    .RISE_TIMEOUT (RTO),
    .DIST_W       (DW),
    .MAX_CM       (MAXCM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_trig"},       int'(sif.trig),        0);
    chk({tag, "_busy"},       int'(sif.busy),        0);
    chk({tag, "_valid"},      int'(sif.dist_valid),  0);
    chk({tag, "_timeout"},    int'(sif.timeout),     0);
    chk({tag, "_dist"},       int'(sif.distance_cm), 0);
    chk({tag, "_saturated"},  int'(sif.saturated),   0);
  endtask

  // Current cycle becomes the first cycle after reset release: first tick is now.
  task automatic release_reset();
    rst       = 1'b0;
    rel0      = cyc;
    exp_trig  = rel0 + 1;
    last_dist = 0;
    last_sat  = 0;
  endtask

  task automatic next_trig_after(input int idle_from);
    int k;
    k = (idle_from - rel0 + PERIOD - 1) / PERIOD;
    exp_trig = rel0 + k * PERIOD + 1;
  endtask

  task automatic wait_trig(input string tag, input bit pre);
    int n;
    int stray;
    n = 0;
    stray = 0;
    if (pre) sif.echo = 1'b1;
    while (sif.trig !== 1'b1 && n < 2000) begin
      if (sif.dist_valid === 1'b1 || sif.timeout === 1'b1) stray++;
      tick();
      n++;
    end
    chk({tag, "_stray_strobe"}, stray, 0);
    chk({tag, "_trig_rise_cyc"}, cyc, exp_trig);
    chk({tag, "_hold_dist"}, int'(sif.distance_cm), last_dist);
  endtask

  task automatic wait_trig_fall(input string tag);
    int w;
    w = 0;
    while (sif.trig === 1'b1 && w < 100) begin
      tick();
      w++;
    end
    chk({tag, "_trig_width"}, w, TRIGC);
  endtask

  // Echo is raw-high for idx in [s, s+len), idx 0 being the first cycle after trig falls.
  task automatic measure(input string tag, input bit pre, input int s, input int len);
    bit meas;
    int exp_idx, exp_d, exp_sat, idle_from;
    int v_cnt, t_cnt, s_idx, s_dist, s_sat;
    meas = !pre && (len > 0);
    wait_trig(tag, pre);
    wait_trig_fall(tag);
    exp_idx = meas ? s + len + 3 : RTO;
    if (meas) begin
      exp_d   = (len / CPC > MAXCM) ? MAXCM : len / CPC;
      exp_sat = (len / CPC > MAXCM) ? 1 : 0;
    end else begin
      exp_d   = last_dist;
      exp_sat = last_sat;
    end
    v_cnt = 0; t_cnt = 0; s_idx = -1; s_dist = -1; s_sat = -1; idle_from = 0;
    for (int idx = 0; idx <= exp_idx + 3; idx++) begin
      if (pre) sif.echo = (idx < 10);
      else     sif.echo = (len > 0 && idx >= s && idx < s + len);
      if (sif.dist_valid === 1'b1) begin
        v_cnt++;
        if (s_idx < 0) begin
          s_idx  = idx;
          s_dist = int'(sif.distance_cm);
          s_sat  = int'(sif.saturated);
        end
      end
      if (sif.timeout === 1'b1) begin
        t_cnt++;
        if (s_idx < 0) s_idx = idx;
      end
      if (idx == exp_idx) idle_from = cyc + (meas ? 1 : 0);
      tick();
    end
    sif.echo = 1'b0;
    chk({tag, "_valid_count"},   v_cnt, meas ? 1 : 0);
    chk({tag, "_timeout_count"}, t_cnt, meas ? 0 : 1);
    chk({tag, "_strobe_idx"},    s_idx, exp_idx);
    if (meas) begin
      chk({tag, "_dist_at_valid"}, s_dist, exp_d);
      chk({tag, "_sat_at_valid"},  s_sat,  exp_sat);
    end
    chk({tag, "_dist_after"}, int'(sif.distance_cm), exp_d);
    chk({tag, "_sat_after"},  int'(sif.saturated),   exp_sat);
    $display("txn %s pre=%0d start=%0d len=%0d dist=%0d sat=%0d strobe_idx=%0d",
             tag, pre, s, len, int'(sif.distance_cm), int'(sif.saturated), s_idx);
    last_dist = exp_d;
    last_sat  = exp_sat;
    next_trig_after(idle_from);
  endtask

  task automatic reset_mid_trig();
    wait_trig("rst_trig", 1'b0);
    tick();
    tick();
    chk("rst_trig_still_high", int'(sif.trig), 1);
    rst = 1'b1;
    tick();
    chk_reset("rst_trig");
    $display("txn rst_trig reset asserted during trigger pulse");
    release_reset();
  endtask

  task automatic reset_mid_measure();
    wait_trig("rst_meas", 1'b0);
    wait_trig_fall("rst_meas");
    for (int idx = 0; idx < 15; idx++) begin
      sif.echo = (idx >= 3);
      tick();
    end
    chk("rst_meas_busy", int'(sif.busy), 1);
    rst = 1'b1;
    sif.echo = 1'b0;
    tick();
    chk_reset("rst_meas");
    $display("txn rst_meas reset asserted during measurement");
    release_reset();
  endtask

  initial begin
    sif.echo = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk_reset("por");
    release_reset();

    measure("no_echo_a", 1'b0, 0, 0);
    measure("no_echo_b", 1'b0, 0, 0);
    measure("w31",       1'b0, 5, 31);
    measure("w100_sat",  1'b0, 5, 100);
    measure("w9_clear",  1'b0, 5, 9);
    measure("w2_zero",   1'b0, 5, 2);
    measure("pre_high",  1'b1, 0, 0);
    measure("late_rise", 1'b0, RTO - 3, 6);
    measure("exact_max", 1'b0, 5, 62);
    measure("over_max",  1'b0, 5, 63);
    for (int i = 0; i < 8; i++) begin
      int s;
      int len;
      s   = int'($urandom_range(0, 40));
      len = int'($urandom_range(1, 90));
      measure($sformatf("rnd%0d", i), 1'b0, s, len);
    end
    measure("w400_skip", 1'b0, 5, 400);
    measure("resume",    1'b0, 5, 12);
    measure("w100_pre_rst", 1'b0, 5, 100);
    reset_mid_trig();
    measure("after_rst_a", 1'b0, 5, 31);
    reset_mid_measure();
    measure("after_rst_b", 1'b0, 5, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonar_ranger.md
Name: sonar_ranger

Overview:
Self-timed ultrasonic ranging front end for the radar display path. It does four things:
- Fires a fixed-width trigger pulse at a fixed repetition period.
- Measures the width of the synchronised echo pulse.
- Converts the width to whole centimetres with a prescaled counter, so no divider is needed.
- Presents the result with a one-cycle valid strobe.

It sits directly upstream of the distance-to-column display stage. It replaces free-running trigger/echo counters with one reset-controlled FSM.

Parameters:
- PERIOD_CYCLES, 6750000: trigger repetition period in clk cycles (0.25 s at 27 MHz).
- TRIG_CYCLES, 270: trig high time in clk cycles (10 us at 27 MHz).
- CLKS_PER_CM, 1566: echo-high clk cycles per centimetre (58 us/cm at 27 MHz).
- RISE_TIMEOUT, 27000: maximum cycles from trig fall to echo rise before the measurement is abandoned.
- DIST_W, 7: width of distance_cm.
- MAX_CM, 127: saturation value for distance_cm; must be at most 2^DIST_W-1.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- echo  input  1  raw sensor echo, asynchronous; 2-flop synchronised internally.
- trig  output  1  sensor trigger pulse.
- distance_cm  output  DIST_W  last valid distance in cm; holds between updates.
- dist_valid  output  1  one-cycle strobe; distance_cm updated in the same cycle.
- timeout  output  1  one-cycle strobe; no echo rise within RISE_TIMEOUT.
- saturated  output  1  level; last result was clipped to MAX_CM.
- busy  output  1  high in every FSM state except IDLE.

Behaviour:
- Reset, on any clk edge with rst=1:
  - FSM goes to IDLE; all counters clear; echo synchroniser flops clear.
  - Outputs: trig=0, distance_cm=0, dist_valid=0, timeout=0, saturated=0, busy=0.
  - Reset mid-pulse drops trig on the next edge. An in-flight measurement is discarded with no strobe.
- Period counter:
  - Free-running 0..PERIOD_CYCLES-1, wraps to 0. Starts at 0 after reset.
  - The wrap tick is the cycle where the counter is 0. The first tick is the cycle after reset release.
- Echo synchroniser:
  - echo_s is echo delayed 2 cycles.
  - Rise = echo_s high and its previous value low. Fall = echo_s low and its previous value high.
- FSM states:
  - IDLE: on a period tick, go to TRIG; trig=1 from the next cycle.
  - TRIG:
    - trig=1 for exactly TRIG_CYCLES cycles, then trig=0 and go to WAIT_RISE.
    - Clear the cm counter and the prescaler on entry.
  - WAIT_RISE:
    - Count cycles. On a rise, go to MEASURE; that cycle is counted as the first echo-high cycle.
    - If the count reaches RISE_TIMEOUT with no rise, pulse timeout for 1 cycle and go to IDLE.
    - Echo already high on entry (no rise) does not start a measurement.
  - MEASURE:
    - Each echo_s-high cycle increments the prescaler.
    - When the prescaler reaches CLKS_PER_CM-1, it resets to 0 and cm increments.
    - cm saturates at MAX_CM; set an internal sat flag when saturation occurs.
    - On a fall, go to DONE.
  - DONE, one cycle:
    - distance_cm <= cm; saturated <= sat flag; dist_valid=1; go to IDLE.
- Result arithmetic: distance_cm = min(floor(H / CLKS_PER_CM), MAX_CM), where H = number of cycles echo_s was high.
- Latency: dist_valid is asserted 1 cycle after the fall is detected, i.e. 3 cycles after raw echo falls.
- Period tick while busy: that period is skipped, with no trigger and no strobe. The next trigger fires on the following tick that finds the FSM in IDLE.
- Strobes: dist_valid and timeout are never asserted in the same cycle. Neither is asserted more than once per trigger.
- distance_cm and saturated change only in DONE or on reset. A timeout does not alter them.
- Counter widths: sized with clog2 of PERIOD_CYCLES, TRIG_CYCLES, RISE_TIMEOUT and CLKS_PER_CM. No wrap-around is permitted in any counter other than the period counter.

Test Plan:
Use PERIOD_CYCLES=200, TRIG_CYCLES=4, CLKS_PER_CM=3, RISE_TIMEOUT=50, MAX_CM=20, DIST_W=7 unless noted.

1. Release reset, echo=0 -> trig high for exactly 4 cycles starting 1 cycle after release. Next trig rises 200 cycles later. timeout pulses once per period, 50 cycles after trig falls. distance_cm stays 0.
2. Echo held high 31 cycles, starting 5 cycles after trig falls -> single dist_valid, distance_cm=10, saturated=0, 3 cycles after echo falls.
3. Echo high 100 cycles -> distance_cm=20, saturated=1. A following 9-cycle echo -> distance_cm=3, saturated=0.
4. Echo high 2 cycles -> distance_cm=0 with dist_valid=1 (valid zero result, not a timeout).
5. Echo high 400 cycles -> one period tick is skipped (no trig while busy). Result distance_cm=20, then triggering resumes on the next tick.
6. Assert rst for 1 cycle mid-trig and again mid-MEASURE -> trig=0 and all outputs at reset values the next cycle. No dist_valid for the aborted measurement. Normal sequence restarts.
